// File: rtl/dev_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, the FSM
// serialises them LSB-first on txd at DIV+1 clk cycles per bit.
//
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for div_q+1 cycles
//   S_DATA  | data bit shift_q[0] for div_q+1 cycles, eight bits
//   S_STOP  | stop bit (high); pops straight into S_START when more is queued
module dev_uart_tx #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    input  logic        wen,
    output logic [15:0] rdata,
    output logic        txd,
    output logic        tx_idle
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_reg_q, div_reg_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic sel, wr_data, wr_stat, wr_div;
    logic full, empty, busy, baud_end, pop, push;

    always_comb begin
        sel      = (addr[11:2] == 10'd0);
        wr_data  = wen && sel && (addr[1:0] == 2'd0);
        wr_stat  = wen && sel && (addr[1:0] == 2'd1);
        wr_div   = wen && sel && (addr[1:0] == 2'd2);
        full     = (count_q == DEPTH_C);
        empty    = (count_q == 5'd0);
        busy     = (state_q != S_IDLE);
        baud_end = (baud_q == 16'd0);
        // A pop at the end of STOP frees a slot in the same edge, so a push
        // to a full FIFO is still accepted then.
        pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
        push     = wr_data && (!full || pop);
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q + {4'd0, push} - {4'd0, pop};
        div_reg_d = wr_div ? wdata : div_reg_q;
        ovf_d     = ovf_q;
        if (wr_data && !push) begin
            ovf_d = 1'b1;
        end else if (wr_stat && wdata[3]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        div_d   = div_q;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    baud_d  = div_q;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
        // DIV is sampled only here, so mid-frame DIV writes wait for the next byte.
        if (pop) begin
            state_d = S_START;
            shift_d = mem_q[rd_ptr_q];
            div_d   = div_reg_q;
            baud_d  = div_reg_q;
            txd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            ovf_q     <= 1'b0;
            div_reg_q <= DIV_RESET;
            div_q     <= 16'd0;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_reg_q <= div_reg_d;
            div_q     <= div_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_comb begin
        rdata = 16'd0;
        if (sel) begin
            case (addr[1:0])
                2'd1:    rdata = {7'd0, count_q, ovf_q, busy, empty, full};
                2'd2:    rdata = div_reg_q;
                default: rdata = 16'd0;
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_idle = empty && (state_q == S_IDLE);

endmodule

// File: doc/dev_uart_tx.md
Name: dev_uart_tx

Overview:
Memory-mapped 8N1 UART transmitter in the device window (0x7000-0x7fff), downstream of the crossbar's device port. Takes the 12-bit device address, write data and write enable. Returns combinational read data, as the single-cycle CPU needs it. Bytes written by the CPU are buffered in a FIFO and serialised LSB-first on txd at a programmable baud rate.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of 2, range 2..16.
DIV_RESET, 433, reset value of the DIV register; bit period = DIV+1 clk cycles.

Ports:
clk  input  1  system clock (clk_soc domain).
rst  input  1  synchronous reset, active-high.
addr  input  12  device-relative word address.
wdata  input  16  write data.
wen  input  1  write enable, sampled on the rising clk edge.
rdata  output  16  read data, combinational from addr and current state.
txd  output  1  serial output, registered, idles high.
tx_idle  output  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Register map (decode addr[1:0] only when addr[11:2]==0; any other address reads 0 and ignores writes):
  - 0x000 DATA:
    - write with FIFO not full: push wdata[7:0]; wdata[15:8] are ignored.
    - write with FIFO full: byte dropped, ovf set.
    - read: returns 0.
  - 0x001 STATUS:
    - read bits: [0]=full, [1]=empty, [2]=busy (FSM not IDLE), [3]=ovf (sticky), [8:4]=count (0..FIFO_DEPTH), [15:9]=0.
    - write with wdata[3]=1: clears ovf. If an overflow occurs in the same cycle, ovf ends set (set wins).
  - 0x002 DIV:
    - read/write, 16 bits, reset DIV_RESET.
    - DIV=0 gives 1 clk per bit.
  - 0x003: reserved, reads 0.
- Reset values: txd=1, tx_idle=1, FIFO empty (count=0), ovf=0, DIV=DIV_RESET, FSM=IDLE, bit counter and baud counter = 0. rdata then reflects STATUS=0x0002 at addr 0x001.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO is non-empty at a clk edge, pop the head into the shift register, latch DIV into div_q, go to START. txd=0 from the next cycle.
  - START: txd=0 for div_q+1 cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for div_q+1 cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for div_q+1 cycles. At the end:
    - FIFO non-empty: pop and re-latch DIV, go directly to START (no idle gap).
    - FIFO empty: go to IDLE.
- Frame length is exactly 10*(div_q+1) cycles.
- Latency: a DATA write to an empty FIFO while IDLE makes txd go low on the 2nd rising edge after the write edge (edge 1 pushes, edge 2 pops).
- DIV writes mid-frame do not affect the current frame; they take effect at the next pop.
- FIFO:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When full, a push coinciding with a pop is accepted, not dropped.
  - A pop only happens when count>0 before the edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - count saturates logically at FIFO_DEPTH and never exceeds it.
- rst asserted mid-frame: at the next edge txd=1, FSM=IDLE, FIFO flushed, DIV restored to DIV_RESET. The partial frame is abandoned.
- Writes while rst is high are ignored.
- tx_idle = empty && FSM==IDLE, registered-equivalent (derived from registered state).

Test Plan:
- Reset: hold rst 3 cycles → txd=1, tx_idle=1, rdata@0x001=0x0002, rdata@0x002=433.
- Single frame: write DIV=3, then DATA=0x1A5 → txd low 2 edges after the write. Expected line is START 0, then data bits 1,0,1,0,0,1,0,1 (0xA5 LSB-first), then STOP 1, each bit 4 cycles, 40 cycles total. tx_idle returns to 1 after STOP.
- Back-to-back: DIV=1, write 0x11, 0x22, 0x33 on consecutive cycles → three 20-cycle frames with no idle gap. STATUS count steps to 2 after the 3rd write (first byte already popped), then decrements 2→1→0 at each frame start.
- Overflow: DIV=0xFFFF, write 18 bytes quickly → first popped, 16 buffered. Last write dropped → STATUS=full|busy|ovf|count16 = 0x010D. Write STATUS 0x0008 → ovf clears, reads 0x0105.
- Full + simultaneous pop: fill 16 with DIV=0. Time a DATA write to the exact edge of a STOP→START pop → byte accepted, ovf stays 0, count stays 16.
- Reset mid-frame: DIV=7, write 0x00, assert rst during bit 3 → txd=1 next edge, count=0, DIV=433, no further low pulses.
